// File: rtl/space_invaders_pkg.sv
// space_invaders_pkg: coordinate width, screen geometry, colours and slot
// state shared by the laser bank and its slots.
package space_invaders_pkg;
   localparam int COORD_W  = 10;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam logic [2:0] COLOR_BLACK = 3'b000;
   localparam logic [2:0] COLOR_BLUE  = 3'b001;
   localparam logic [2:0] COLOR_GREEN = 3'b010;
   localparam logic [2:0] COLOR_RED   = 3'b100;
   localparam logic [2:0] COLOR_WHITE = 3'b111;
   typedef enum logic {
      SLOT_IDLE   = 1'b0,
      SLOT_FLYING = 1'b1
   } slot_state_e;
endpackage

// File: rtl/laser_slot.sv
// laser_slot: one projectile -- launch, upward motion, retirement and the
// pixel hit test against its rectangle.
module laser_slot
   import space_invaders_pkg::*;
#(
   parameter int LAUNCH_Y    = 432,
   parameter int LASER_LEN   = 8,
   parameter int LASER_WIDTH = 2,
   parameter int STEP        = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_tick,
   input  logic               i_launch,
   input  logic               i_kill,
   input  logic [COORD_W-1:0] i_launch_x,
   input  logic [COORD_W-1:0] i_h,
   input  logic [COORD_W-1:0] i_v,
   output logic               o_active,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   output logic               o_hit
);
   localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
   localparam logic [COORD_W-1:0] LAUNCH_C = COORD_W'(LAUNCH_Y);
   localparam logic [COORD_W:0]   LW       = (COORD_W+1)'(LASER_WIDTH);
   localparam logic [COORD_W:0]   LL       = (COORD_W+1)'(LASER_LEN);

   slot_state_e        r_state, w_state_next;
   logic [COORD_W-1:0] r_x, r_y, w_x_next, w_y_next;
   logic [COORD_W:0]   w_h, w_v, w_x, w_y;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= SLOT_IDLE;
         r_x     <= '0;
         r_y     <= '0;
      end else begin
         r_state <= w_state_next;
         r_x     <= w_x_next;
         r_y     <= w_y_next;
      end
   end

   // kill outranks motion; a slot below STEP retires rather than wrapping
   always_comb begin
      w_state_next = r_state;
      w_x_next     = r_x;
      w_y_next     = r_y;
      if (r_state == SLOT_IDLE) begin
         if (i_launch) begin
            w_state_next = SLOT_FLYING;
            w_x_next     = i_launch_x;
            w_y_next     = LAUNCH_C;
         end
      end else if (i_kill) begin
         w_state_next = SLOT_IDLE;
      end else if (i_tick) begin
         if (r_y >= STEP_C) w_y_next = r_y - STEP_C;
         else w_state_next = SLOT_IDLE;
      end
   end

   assign w_h = {1'b0, i_h};
   assign w_v = {1'b0, i_v};
   assign w_x = {1'b0, r_x};
   assign w_y = {1'b0, r_y};

   assign o_active = (r_state == SLOT_FLYING);
   assign o_x      = r_x;
   assign o_y      = r_y;
   assign o_hit    = o_active && (w_h >= w_x) && (w_h < w_x + LW)
                     && (w_v >= w_y) && (w_v < w_y + LL);
endmodule

// File: rtl/laser_bank.sv
// laser_bank: multi-shot laser controller -- free-slot launch, shot cooldown,
// kill decode and registered pixel colour over NUM_LASERS slots.
module laser_bank
   import space_invaders_pkg::*;
#(
   parameter int         NUM_LASERS     = 4,
   parameter int         GUN_Y          = 440,
   parameter int         LASER_LEN      = 8,
   parameter int         LASER_WIDTH    = 2,
   parameter int         STEP           = 4,
   parameter int         COOLDOWN_TICKS = 8,
   parameter logic [2:0] LASER_COLOR    = 3'b111
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tick,
   input  logic                          fire,
   input  logic [COORD_W-1:0]            gunPosition,
   input  logic                          killingAlien,
   input  logic [2:0]                    killIndex,
   input  logic [COORD_W-1:0]            hPos,
   input  logic [COORD_W-1:0]            vPos,
   output logic [NUM_LASERS-1:0]         laserActive,
   output logic [COORD_W*NUM_LASERS-1:0] xLaser,
   output logic [COORD_W*NUM_LASERS-1:0] yLaser,
   output logic                          fireAccepted,
   output logic [2:0]                    colorLaser
);
   localparam int            CD_W    = $clog2(COOLDOWN_TICKS + 1) + 1;
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_TICKS);

   logic [CD_W-1:0]       r_cooldown;
   logic [NUM_LASERS-1:0] w_idle, w_pick, w_launch, w_kill, w_hit;
   logic                  w_accept;

   // lowest set bit of the idle mask picks the slot to launch
   assign w_idle   = ~laserActive;
   assign w_pick   = w_idle & (~w_idle + NUM_LASERS'(1));
   assign w_accept = fire && (r_cooldown == '0) && (|w_idle);
   assign w_launch = w_accept ? w_pick : '0;

   for (genvar i = 0; i < NUM_LASERS; i++) begin : g_slot
      assign w_kill[i] = killingAlien && (killIndex == 3'(i));
      laser_slot #(
         .LAUNCH_Y   (GUN_Y - LASER_LEN),
         .LASER_LEN  (LASER_LEN),
         .LASER_WIDTH(LASER_WIDTH),
         .STEP       (STEP)
      ) u_slot (
         .clk       (clk),
         .reset     (reset),
         .i_tick    (tick),
         .i_launch  (w_launch[i]),
         .i_kill    (w_kill[i]),
         .i_launch_x(gunPosition),
         .i_h       (hPos),
         .i_v       (vPos),
         .o_active  (laserActive[i]),
         .o_x       (xLaser[COORD_W*i +: COORD_W]),
         .o_y       (yLaser[COORD_W*i +: COORD_W]),
         .o_hit     (w_hit[i])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cooldown   <= '0;
         fireAccepted <= 1'b0;
         colorLaser   <= COLOR_BLACK;
      end else begin
         r_cooldown   <= w_accept ? CD_LOAD
                       : (tick && r_cooldown != '0) ? r_cooldown - 1'b1 : r_cooldown;
         fireAccepted <= w_accept;
         colorLaser   <= (|w_hit) ? LASER_COLOR : COLOR_BLACK;
      end
   end
endmodule

// File: tb/tb_laser_bank.sv
// tb_laser_bank: directed stimulus pushes expectations into queues; a
// negedge monitor pops and compares whenever the DUT shows a result.
module tb_laser_bank;
   logic        clk, reset, tick, fire, killingAlien;
   logic [9:0]  gunPosition, hPos, vPos;
   logic [2:0]  killIndex, colorLaser;
   logic [3:0]  laserActive;
   logic [39:0] xLaser, yLaser;
   logic        fireAccepted;

   typedef struct packed {
      logic [3:0]  act;
      logic [39:0] xs;
      logic [39:0] ys;
      logic [2:0]  col;
      logic        ccol;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   bit    acc_q[$];
   int    n_pass = 0;
   int    n_total = 0;
   exp_t  e;
   string nm;

   laser_bank dut (
      .clk(clk), .reset(reset), .tick(tick), .fire(fire),
      .gunPosition(gunPosition), .killingAlien(killingAlien), .killIndex(killIndex),
      .hPos(hPos), .vPos(vPos), .laserActive(laserActive), .xLaser(xLaser),
      .yLaser(yLaser), .fireAccepted(fireAccepted), .colorLaser(colorLaser)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fireAccepted) begin
         n_total++;
         if (acc_q.size() == 0) $display("FAIL fire_pulse: got fireAccepted=1 want 0");
         else begin
            void'(acc_q.pop_front());
            n_pass++;
         end
      end
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_total++;
         if (laserActive == e.act && xLaser == e.xs && yLaser == e.ys
             && (!e.ccol || colorLaser == e.col)) n_pass++;
         else $display("FAIL %s: got act=%b x=%h y=%h col=%b want act=%b x=%h y=%h col=%b",
                       nm, laserActive, xLaser, yLaser, colorLaser, e.act, e.xs, e.ys, e.col);
      end
   end

   function automatic logic [39:0] pk(input logic [9:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic step(input bit f, input bit t, input bit k, input logic [2:0] ki);
      fire = f; tick = t; killingAlien = k; killIndex = ki;
      @(posedge clk);
      #1;
      fire = 0; tick = 0; killingAlien = 0;
   endtask

   task automatic ticks(input int n);
      repeat (n) step(0, 1, 0, 3'd0);
   endtask

   task automatic pix(input logic [9:0] h, input logic [9:0] v);
      hPos = h; vPos = v;
      step(0, 0, 0, 3'd0);
   endtask

   task automatic chk(input string n, input logic [3:0] a, input logic [39:0] xs,
                      input logic [39:0] ys, input logic [2:0] col, input bit ccol);
      exp_q.push_back('{act: a, xs: xs, ys: ys, col: col, ccol: ccol});
      name_q.push_back(n);
      @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      reset = 1; fire = 0; tick = 0; killingAlien = 0; killIndex = 0;
      gunPosition = 0; hPos = 0; vPos = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 4'b0000, 40'd0, 40'd0, 3'd0, 1);
      reset = 0;
      gunPosition = 10'd300; acc_q.push_back(1); step(1, 0, 0, 3'd0);
      chk("launch0", 4'b0001, pk(10'd300, 10'd0, 10'd0, 10'd0), pk(10'd432, 10'd0, 10'd0, 10'd0), 3'd0, 1);
      ticks(5);
      chk("move5", 4'b0001, pk(10'd300, 10'd0, 10'd0, 10'd0), pk(10'd412, 10'd0, 10'd0, 10'd0), 3'd0, 0);
      pix(10'd301, 10'd415);
      chk("pix_hit", 4'b0001, pk(10'd300, 10'd0, 10'd0, 10'd0), pk(10'd412, 10'd0, 10'd0, 10'd0), 3'b111, 1);
      pix(10'd302, 10'd415);
      chk("pix_right", 4'b0001, pk(10'd300, 10'd0, 10'd0, 10'd0), pk(10'd412, 10'd0, 10'd0, 10'd0), 3'd0, 1);
      pix(10'd301, 10'd420);
      chk("pix_below", 4'b0001, pk(10'd300, 10'd0, 10'd0, 10'd0), pk(10'd412, 10'd0, 10'd0, 10'd0), 3'd0, 1);
      hPos = 0; vPos = 0;
      ticks(3);
      gunPosition = 10'd100; acc_q.push_back(1); step(1, 0, 0, 3'd0);
      chk("launch1", 4'b0011, pk(10'd300, 10'd100, 10'd0, 10'd0), pk(10'd400, 10'd432, 10'd0, 10'd0), 3'd0, 0);
      ticks(1);
      step(1, 0, 0, 3'd0);
      chk("cooldown_drop", 4'b0011, pk(10'd300, 10'd100, 10'd0, 10'd0), pk(10'd396, 10'd428, 10'd0, 10'd0), 3'd0, 0);
      ticks(8);
      gunPosition = 10'd200; acc_q.push_back(1); step(1, 0, 0, 3'd0);
      chk("launch2", 4'b0111, pk(10'd300, 10'd100, 10'd200, 10'd0), pk(10'd364, 10'd396, 10'd432, 10'd0), 3'd0, 0);
      ticks(9);
      gunPosition = 10'd500; acc_q.push_back(1); step(1, 0, 0, 3'd0);
      chk("launch3", 4'b1111, pk(10'd300, 10'd100, 10'd200, 10'd500), pk(10'd328, 10'd360, 10'd396, 10'd432), 3'd0, 0);
      ticks(9);
      gunPosition = 10'd600; step(1, 0, 0, 3'd0);
      chk("full_drop", 4'b1111, pk(10'd300, 10'd100, 10'd200, 10'd500), pk(10'd292, 10'd324, 10'd360, 10'd396), 3'd0, 0);
      step(0, 0, 1, 3'd2);
      chk("kill2", 4'b1011, pk(10'd300, 10'd100, 10'd200, 10'd500), pk(10'd292, 10'd324, 10'd360, 10'd396), 3'd0, 0);
      gunPosition = 10'd50; acc_q.push_back(1); step(1, 0, 1, 3'd1);
      chk("kill1_fire", 4'b1101, pk(10'd300, 10'd100, 10'd50, 10'd500), pk(10'd292, 10'd324, 10'd432, 10'd396), 3'd0, 0);
      step(0, 0, 1, 3'd1);
      chk("kill_idle", 4'b1101, pk(10'd300, 10'd100, 10'd50, 10'd500), pk(10'd292, 10'd324, 10'd432, 10'd396), 3'd0, 0);
      step(0, 0, 1, 3'd6);
      chk("kill_range", 4'b1101, pk(10'd300, 10'd100, 10'd50, 10'd500), pk(10'd292, 10'd324, 10'd432, 10'd396), 3'd0, 0);
      ticks(72);
      chk("y4", 4'b1101, pk(10'd300, 10'd100, 10'd50, 10'd500), pk(10'd4, 10'd324, 10'd144, 10'd108), 3'd0, 0);
      ticks(1);
      chk("y0", 4'b1101, pk(10'd300, 10'd100, 10'd50, 10'd500), pk(10'd0, 10'd324, 10'd140, 10'd104), 3'd0, 0);
      ticks(1);
      chk("exit_top", 4'b1100, pk(10'd300, 10'd100, 10'd50, 10'd500), pk(10'd0, 10'd324, 10'd136, 10'd100), 3'd0, 0);
      gunPosition = 10'd20; acc_q.push_back(1); step(1, 0, 0, 3'd0);
      chk("launch_three", 4'b1101, pk(10'd20, 10'd100, 10'd50, 10'd500), pk(10'd432, 10'd324, 10'd136, 10'd100), 3'd0, 0);
      reset = 1;
      chk("reset_mid", 4'b0000, 40'd0, 40'd0, 3'd0, 1);
      reset = 0;
      gunPosition = 10'd1022; acc_q.push_back(1); step(1, 0, 0, 3'd0);
      chk("relaunch", 4'b0001, pk(10'd1022, 10'd0, 10'd0, 10'd0), pk(10'd432, 10'd0, 10'd0, 10'd0), 3'd0, 0);
      pix(10'd1023, 10'd435);
      chk("pix_edge", 4'b0001, pk(10'd1022, 10'd0, 10'd0, 10'd0), pk(10'd432, 10'd0, 10'd0, 10'd0), 3'b111, 1);
      pix(10'd0, 10'd435);
      chk("pix_wrap", 4'b0001, pk(10'd1022, 10'd0, 10'd0, 10'd0), pk(10'd432, 10'd0, 10'd0, 10'd0), 3'd0, 1);
      pix(10'd1023, 10'd440);
      chk("pix_len", 4'b0001, pk(10'd1022, 10'd0, 10'd0, 10'd0), pk(10'd432, 10'd0, 10'd0, 10'd0), 3'd0, 1);
      n_total++;
      if (acc_q.size() == 0) n_pass++;
      else $display("FAIL fire_missing: got %0d pending pulses want 0", acc_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/laser_bank.md
# laser_bank

Multi-shot laser controller that supersedes the single-shot laser. Manages `NUM_LASERS` independent projectiles fired from the spaceship gun, advances them once per movement tick, and retires them on a screen-top exit or an alien kill. Exports per-slot coordinates to the collision logic and drives a registered pixel colour into the final-colour mux alongside the spaceship and aliens.

## Interface

Parameters:
- `NUM_LASERS`, 4: number of independent laser slots (1..8).
- `GUN_Y`, 440: row of the gun tip; a new laser's top edge is `GUN_Y - LASER_LEN`.
- `LASER_LEN`, 8: laser height in pixels.
- `LASER_WIDTH`, 2: laser width in pixels.
- `STEP`, 4: pixels moved upward per `tick`.
- `COOLDOWN_TICKS`, 8: ticks after an accepted shot before another is accepted.
- `LASER_COLOR`, 3'b111: colour emitted on laser pixels.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle movement enable from a TimeUnitEnable instance.
- `fire`  in  1  one-cycle fire pulse from the debounced button.
- `gunPosition`  in  10  x coordinate of the gun's left edge.
- `killingAlien`  in  1  one-cycle pulse: laser `killIndex` hit an alien.
- `killIndex`  in  3  slot index for `killingAlien`.
- `hPos`, `vPos`  in  10 each  current VGA pixel.
- `laserActive`  out  NUM_LASERS  per-slot flying flag.
- `xLaser`, `yLaser`  out  10*NUM_LASERS each  packed slot coordinates; slot i at bits [10i+9:10i].
- `fireAccepted`  out  1  one-cycle pulse when a shot launches.
- `colorLaser`  out  3  pixel colour, 0 where no laser.

## Operation

- Each slot: IDLE or FLYING, plus 10-bit x and y (top edge). Reset: all IDLE, x = y = 0, cooldown = 0, `fireAccepted` = 0, `colorLaser` = 0.
- Launch: `fire` high, cooldown == 0, and at least one slot IDLE (state before this edge) -> lowest-index IDLE slot becomes FLYING with x = `gunPosition`, y = `GUN_Y - LASER_LEN`. Cooldown loads `COOLDOWN_TICKS`. `fireAccepted` pulses. Otherwise `fire` is dropped, not queued.
- Cooldown decrements by 1 on each `tick` while nonzero. The decrement is skipped on the cycle it is loaded.
- Move: on `tick`, each FLYING slot with y >= STEP gets y -= STEP. A slot with y < STEP returns to IDLE, with x and y held.
- Kill: `killingAlien` with `killIndex` < NUM_LASERS and that slot FLYING -> slot IDLE. Kills naming an IDLE or out-of-range slot are ignored.
- Per-slot priority, same cycle: kill > move. A slot freed this cycle is not launchable until the next cycle.
- A newly launched slot does not also move on the launch cycle, even if `tick` is high.
- Pixel: hit when any FLYING slot satisfies x <= hPos < x+LASER_WIDTH and y <= vPos < y+LASER_LEN. Compare in 11-bit arithmetic so no overflow occurs at x near 1023.

## Timing

- State, `laserActive`, `xLaser`, `yLaser`: updated on the rising edge after the triggering input and visible 1 cycle later.
- `fireAccepted`: registered, high the cycle after the accepted `fire`.
- `colorLaser`: registered, 1 cycle after `hPos`/`vPos`. The top level delays the other colour sources to match.
- `reset` asserted mid-flight clears every slot immediately (asynchronous). The first launch is possible on the first edge after deassertion.

## Structure

- Shared package `space_invaders_pkg`: `COORD_W` = 10, screen constants (640x480), 3-bit colour constants, and the slot state enum.
- Sub-module `laser_slot`: one slot's FSM, position registers and hit compare, instantiated NUM_LASERS times via generate.
- The top holds free-slot priority encoding, cooldown counter, kill decode and the OR-reduce of hits.

## Test plan

- Reset, then `fire` with `gunPosition`=300 -> `fireAccepted` pulses; slot 0 FLYING at x=300, y=432; `laserActive`=4'b0001.
- 5 `tick`s after launch -> slot 0 y=412. Pixel at (301,415) -> `colorLaser`=3'b111. Pixel at (302,415) -> 0.
- `fire` every 9 ticks, 5 times, with no kills -> slots 0..3 fill; 5th `fire` dropped with `fireAccepted`=0. `fire` again 1 tick after launch -> dropped by cooldown.
- Slot 1 FLYING, `killingAlien` with `killIndex`=1 and `fire` in the same cycle -> slot 1 IDLE; launch goes to the lowest slot that was IDLE before the edge, not slot 1.
- Slot at y=3 with `tick` -> slot IDLE, no wrap to 1023. `killIndex`=6 with NUM_LASERS=4 -> no change.
- `reset` pulse with 3 slots flying -> all outputs 0 within the same cycle; next `fire` lands in slot 0.
